soc_test_monitor: RTL and testbench
===================================

# soc_test_monitor

Synthesizable, parametrised test monitor that sits beside the RISC-V core on the data-memory bus and replaces fixed-delay result printing in the SoC bench. It snoops data-bus writes and decodes a `tohost` completion word into pass/fail/exit code. It also captures a bank of signature words and counts run cycles and fetches. A cycle watchdog flags hung programs. All results are registered outputs that benches, or an on-chip status port, can sample deterministically.

## Interface
Parameters:
- `DATA_W`, 32: bus data width.
- `ADDR_W`, 32: bus address width.
- `TOHOST_ADDR`, 32'h0000_0100: word address of the completion register.
- `SIG_BASE`, 32'h0000_0200: base address of the signature window.
- `SIG_NUM`, 4: number of signature words, 1..16.
- `TIMEOUT`, 100000: cycle limit in RUN state, ≥ 2.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: **reset is synchronous and active-low** (asserted when 0, sampled on `clk` rising edge).
- `inst_ce` in 1: core instruction-fetch enable.
- `data_ce` in 1: data-bus chip enable.
- `data_we` in 1: data-bus write enable.
- `data_addr` in ADDR_W: data-bus address.
- `data_wdata` in DATA_W: data-bus write data.
- `done` out 1: terminal state reached, sticky.
- `pass` out 1: completion word == 1.
- `fail` out 1: odd completion word ≠ 1.
- `timeout` out 1: watchdog expired.
- `exit_code` out DATA_W-1: completion word bits [DATA_W-1:1].
- `cycle_cnt` out 32: cycles spent in RUN.
- `inst_cnt` out 32: `inst_ce`-high cycles in RUN.
- `sig` out SIG_NUM*DATA_W: signature words; word i occupies bits [i*DATA_W +: DATA_W].

## Operation
- Bus write strobe: `wr = data_ce & data_we`.
- Write hit on TOHOST_ADDR: `wr` and `data_addr == TOHOST_ADDR`.
- FSM states:
  - IDLE → RUN on the first cycle with `inst_ce`=1. That cycle counts as cycle 0 of RUN: `cycle_cnt` and `inst_cnt` each increment.
  - RUN → PASS on a TOHOST write with data == 1.
  - RUN → FAIL on a TOHOST write with odd data ≠ 1. `exit_code` loads data[DATA_W-1:1].
  - TOHOST writes with even data are ignored.
  - RUN → TIMEOUT when `cycle_cnt == TIMEOUT-1` and no PASS/FAIL write occurs that cycle.
  - PASS, FAIL and TIMEOUT are terminal. Only reset leaves them.
- Priority: a TOHOST write on the watchdog's final cycle wins over TIMEOUT.
- Signature capture (RUN only): `wr` with `data_addr[1:0]==0` and `SIG_BASE ≤ data_addr < SIG_BASE+4*SIG_NUM` writes `sig[(data_addr-SIG_BASE)>>2]`.
  - Misaligned or out-of-window writes are ignored.
  - Writes in IDLE or a terminal state are ignored.
- Counters:
  - 32-bit, increment only in RUN, saturate at 2^32-1.
  - Frozen once a terminal state is reached.
- Address arithmetic: subtraction done at ADDR_W bits; comparison is unsigned.
- Reset (rst=0, any state, including mid-RUN):
  - State → IDLE.
  - All outputs → 0: `done`, `pass`, `fail`, `timeout`, `exit_code`, `cycle_cnt`, `inst_cnt`, every `sig` word.

## Timing
- All outputs are registered.
- A write sampled on edge N is visible after edge N: flags and `sig` update in the same cycle the next core instruction executes.
- `done` = pass | fail | timeout, asserted together with its cause flag.
- Exactly one cause flag is ever high.
- No combinational path from inputs to outputs.
- No backpressure: the block never stalls the bus.
- Simultaneous events in one cycle:
  - A signature write and a TOHOST write cannot alias, since their addresses differ; if parameters make them overlap, TOHOST decoding takes precedence and the signature write is dropped.
  - `inst_ce` on the terminating cycle is counted.

## Structure
- Shared package `soc_test_pkg`:
  - state enum (IDLE, RUN, PASS, FAIL, TIMEOUT);
  - `TOHOST_PASS` = 1 constant;
  - default addresses.
- One sub-module, `sig_regfile`: SIG_NUM×DATA_W register bank with write-enable, index and synchronous active-low clear.
- Top level holds the FSM, address decode, counters and watchdog.
- Target size ~200 lines.

## Test plan
- Release reset, then write TOHOST=1 at cycle 50 of RUN → pass=1, done=1, fail=timeout=0, cycle_cnt=51, all flags stay high for 100 more cycles.
- Write TOHOST=0x0000_0007 → fail=1, exit_code=3. A later write of 1 → still fail, exit_code=3.
- TIMEOUT=20, no TOHOST writes → timeout=1 after cycle_cnt reaches 20. TOHOST write on the 20th RUN cycle instead → pass=1, timeout=0.
- Writes of 0xA5 to SIG_BASE+8, 0x11 to SIG_BASE+2 (misaligned), 0x22 to SIG_BASE+16 (out of window, SIG_NUM=4) → sig[2]=0xA5; other words stay 0.
- Pull rst low for one cycle mid-RUN with cycle_cnt=30 and sig[0]=0xFF → next cycle all outputs are 0 and state is IDLE. Counting resumes from 0 on the next `inst_ce`.
- TOHOST write with data 2 (even) → no flag change. Bus writes with `data_ce`=0 are never captured.

Source files
------------

// File: rtl/soc_test_pkg.sv
// -----------------------------------------------------------------------------
// soc_test_pkg
//
// Shared definitions for the SoC test monitor:
//   - state_t      : monitor FSM states (idle, running, and three terminal states)
//   - TOHOST_PASS  : completion word that signals a passing program
//   - DEF_*        : default bus addresses and limits used as parameter defaults
//   - idx_width()  : width of a word index into an n-entry bank (at least 1 bit)
//   - sat_inc32()  : 32-bit increment that sticks at all-ones
// -----------------------------------------------------------------------------
package soc_test_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_PASS    = 3'd2,
    ST_FAIL    = 3'd3,
    ST_TIMEOUT = 3'd4
  } state_t;

  localparam int unsigned TOHOST_PASS = 1;

  localparam logic [31:0] DEF_TOHOST_ADDR = 32'h0000_0100;
  localparam logic [31:0] DEF_SIG_BASE    = 32'h0000_0200;
  localparam int unsigned DEF_SIG_NUM     = 4;
  localparam int unsigned DEF_TIMEOUT     = 100000;

  // A one-entry bank still needs a 1-bit index port.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Run counters must never wrap back to a small value on very long runs.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/sig_regfile.sv
// -----------------------------------------------------------------------------
// sig_regfile
//
// SIG_NUM x DATA_W bank of signature registers with a single write port.
//
// Ports:
//   clk    in  1                 clock, rising edge
//   rst    in  1                 synchronous active-low clear of every word
//   we     in  1                 write enable
//   idx    in  IDX_W             word index to write (caller keeps it in range)
//   wdata  in  DATA_W            write data
//   sig    out SIG_NUM*DATA_W    all words, word i at [i*DATA_W +: DATA_W]
// -----------------------------------------------------------------------------
module sig_regfile
  import soc_test_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned SIG_NUM = DEF_SIG_NUM,
  parameter int unsigned IDX_W   = idx_width(SIG_NUM)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        we,
  input  logic [IDX_W-1:0]            idx,
  input  logic [DATA_W-1:0]           wdata,
  output logic [SIG_NUM*DATA_W-1:0]   sig
);

  logic [SIG_NUM-1:0][DATA_W-1:0] bank;

  // NOTE: this bank is a small flop array, not a RAM macro, so it can and must
  // be cleared by reset: the bench reads every word as 0 after reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bank <= '0;
    end else if (we) begin
      bank[idx] <= wdata;
    end
  end

  assign sig = bank;

endmodule

// File: rtl/soc_test_monitor.sv
// -----------------------------------------------------------------------------
// soc_test_monitor
//
// Passive monitor on the core's data-memory bus. It watches for a write to the
// tohost completion register and decodes it into pass / fail + exit code,
// captures a small window of signature words, counts run cycles and fetch
// cycles, and raises a timeout if the program never reports completion.
// Every output comes straight from a flop; nothing on the bus is ever stalled.
//
// Ports:
//   clk         in  1               clock, rising edge
//   rst         in  1               synchronous active-low reset
//   inst_ce     in  1               instruction fetch enable (starts and counts RUN)
//   data_ce     in  1               data bus chip enable
//   data_we     in  1               data bus write enable
//   data_addr   in  ADDR_W          data bus address
//   data_wdata  in  DATA_W          data bus write data
//   done        out 1               sticky: a terminal state has been reached
//   pass        out 1               completion word was TOHOST_PASS
//   fail        out 1               completion word was odd and not TOHOST_PASS
//   timeout     out 1               watchdog expired before completion
//   exit_code   out DATA_W-1        completion word bits [DATA_W-1:1] on fail
//   cycle_cnt   out 32              cycles spent in RUN (saturating)
//   inst_cnt    out 32              inst_ce-high cycles in RUN (saturating)
//   sig         out SIG_NUM*DATA_W  signature words, word i at [i*DATA_W +: DATA_W]
// -----------------------------------------------------------------------------
module soc_test_monitor
  import soc_test_pkg::*;
#(
  parameter int unsigned       DATA_W      = 32,
  parameter int unsigned       ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR = ADDR_W'(DEF_TOHOST_ADDR),
  parameter logic [ADDR_W-1:0] SIG_BASE    = ADDR_W'(DEF_SIG_BASE),
  parameter int unsigned       SIG_NUM     = DEF_SIG_NUM,
  parameter int unsigned       TIMEOUT     = DEF_TIMEOUT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       inst_ce,
  input  logic                       data_ce,
  input  logic                       data_we,
  input  logic [ADDR_W-1:0]          data_addr,
  input  logic [DATA_W-1:0]          data_wdata,
  output logic                       done,
  output logic                       pass,
  output logic                       fail,
  output logic                       timeout,
  output logic [DATA_W-2:0]          exit_code,
  output logic [31:0]                cycle_cnt,
  output logic [31:0]                inst_cnt,
  output logic [SIG_NUM*DATA_W-1:0]  sig
);

  localparam int unsigned       IDX_W     = idx_width(SIG_NUM);
  // Size of the signature window in bytes.
  localparam logic [ADDR_W-1:0] SIG_SPAN  = ADDR_W'(4 * SIG_NUM);
  localparam logic [DATA_W-1:0] PASS_WORD = DATA_W'(TOHOST_PASS);
  // Value of cycle_cnt on the last cycle the watchdog allows.
  localparam logic [31:0]       WD_LAST   = 32'(TIMEOUT - 1);

  state_t state;

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  logic              is_run;
  logic              wr;
  logic              tohost_hit;
  logic              tohost_pass;
  logic              tohost_fail;
  logic              wd_expire;
  logic [ADDR_W-1:0] sig_off;
  logic              sig_we;
  logic [IDX_W-1:0]  sig_idx;

  always_comb begin
    // NOTE: every signal driven here gets a value on every path before any
    // condition, so no latch can be inferred.
    is_run      = (state == ST_RUN);
    wr          = data_ce & data_we;
    tohost_hit  = wr && (data_addr == TOHOST_ADDR);
    tohost_pass = is_run && tohost_hit && (data_wdata == PASS_WORD);
    // Even completion words are not results and are ignored.
    tohost_fail = is_run && tohost_hit && data_wdata[0] && (data_wdata != PASS_WORD);
    // A completion write on the final watchdog cycle takes priority over timeout.
    wd_expire   = is_run && (cycle_cnt == WD_LAST) && !tohost_pass && !tohost_fail;

    // Unsigned subtraction at address width; the lower-bound compare below
    // rejects addresses under the window whose offset wrapped around.
    sig_off = data_addr - SIG_BASE;
    sig_idx = sig_off[IDX_W+1:2];
    sig_we  = 1'b0;
    if (is_run && wr && !tohost_hit && (data_addr[1:0] == 2'b00) &&
        (data_addr >= SIG_BASE) && (sig_off < SIG_SPAN)) begin
      sig_we = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM, result flags and run counters
  // ---------------------------------------------------------------------------
  // NOTE: all state below uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_IDLE;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail      <= 1'b0;
      timeout   <= 1'b0;
      exit_code <= '0;
      cycle_cnt <= '0;
      inst_cnt  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          // The first fetch cycle is already cycle 0 of the run and is counted.
          if (inst_ce) begin
            state     <= ST_RUN;
            cycle_cnt <= sat_inc32(cycle_cnt);
            inst_cnt  <= sat_inc32(inst_cnt);
          end
        end

        ST_RUN: begin
          // The terminating cycle is still a run cycle and is counted too.
          cycle_cnt <= sat_inc32(cycle_cnt);
          if (inst_ce) begin
            inst_cnt <= sat_inc32(inst_cnt);
          end

          if (tohost_pass) begin
            state <= ST_PASS;
            pass  <= 1'b1;
            done  <= 1'b1;
          end else if (tohost_fail) begin
            state     <= ST_FAIL;
            fail      <= 1'b1;
            done      <= 1'b1;
            exit_code <= data_wdata[DATA_W-1:1];
          end else if (wd_expire) begin
            state   <= ST_TIMEOUT;
            timeout <= 1'b1;
            done    <= 1'b1;
          end
        end

        // Terminal states hold flags and counters until reset.
        default: begin
          state <= state;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Signature bank
  // ---------------------------------------------------------------------------
  sig_regfile #(
    .DATA_W  (DATA_W),
    .SIG_NUM (SIG_NUM),
    .IDX_W   (IDX_W)
  ) u_sig_regfile (
    .clk   (clk),
    .rst   (rst),
    .we    (sig_we),
    .idx   (sig_idx),
    .wdata (data_wdata),
    .sig   (sig)
  );

endmodule

// File: tb/tb_soc_test_monitor.sv
// -----------------------------------------------------------------------------
// tb_soc_test_monitor
//
// Two monitor instances share one bus: dut uses default parameters, dut_wd has
// a 20-cycle watchdog. Stimulus pushes hand-computed expectations into a
// queue tagged with the cycle they apply to; a separate negedge process pops
// and compares them against the DUT outputs.
// -----------------------------------------------------------------------------
module tb_soc_test_monitor;

  localparam logic [31:0] TOHOST = 32'h0000_0100;
  localparam logic [31:0] SIGB   = 32'h0000_0200;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        inst_ce = 1'b0;
  logic        data_ce = 1'b0;
  logic        data_we = 1'b0;
  logic [31:0] data_addr = '0;
  logic [31:0] data_wdata = '0;

  logic         d_done, d_pass, d_fail, d_timeout;
  logic [30:0]  d_exit;
  logic [31:0]  d_cyc, d_inst;
  logic [127:0] d_sig;

  logic         w_done, w_pass, w_fail, w_timeout;
  logic [30:0]  w_exit;
  logic [31:0]  w_cyc, w_inst;
  logic [127:0] w_sig;

  soc_test_monitor dut (
    .clk(clk), .rst(rst), .inst_ce(inst_ce), .data_ce(data_ce), .data_we(data_we),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .done(d_done), .pass(d_pass), .fail(d_fail), .timeout(d_timeout),
    .exit_code(d_exit), .cycle_cnt(d_cyc), .inst_cnt(d_inst), .sig(d_sig)
  );

  soc_test_monitor #(.TIMEOUT(20)) dut_wd (
    .clk(clk), .rst(rst), .inst_ce(inst_ce), .data_ce(data_ce), .data_we(data_we),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .done(w_done), .pass(w_pass), .fail(w_fail), .timeout(w_timeout),
    .exit_code(w_exit), .cycle_cnt(w_cyc), .inst_cnt(w_inst), .sig(w_sig)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef enum int {
    F_DONE, F_PASS, F_FAIL, F_TMO, F_EXIT, F_CYC, F_INST,
    F_SIG0, F_SIG1, F_SIG2, F_SIG3,
    W_DONE, W_PASS, W_FAIL, W_TMO, W_CYC
  } field_t;

  typedef struct {
    string       name;
    field_t      f;
    logic [63:0] v;
    int          due;
  } exp_t;

  exp_t sb[$];

  function automatic logic [63:0] read_field(input field_t f);
    case (f)
      F_DONE:  return 64'(d_done);
      F_PASS:  return 64'(d_pass);
      F_FAIL:  return 64'(d_fail);
      F_TMO:   return 64'(d_timeout);
      F_EXIT:  return 64'(d_exit);
      F_CYC:   return 64'(d_cyc);
      F_INST:  return 64'(d_inst);
      F_SIG0:  return 64'(d_sig[31:0]);
      F_SIG1:  return 64'(d_sig[63:32]);
      F_SIG2:  return 64'(d_sig[95:64]);
      F_SIG3:  return 64'(d_sig[127:96]);
      W_DONE:  return 64'(w_done);
      W_PASS:  return 64'(w_pass);
      W_FAIL:  return 64'(w_fail);
      W_TMO:   return 64'(w_timeout);
      W_CYC:   return 64'(w_cyc);
      default: return 64'hDEAD_BEEF_DEAD_BEEF;
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Monitor: compare every expectation whose cycle has been reached.
  always @(negedge clk) begin : monitor
    exp_t e;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      check(e.name, read_field(e.f), e.v);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_f(input string name, input field_t f, input logic [63:0] v);
    exp_t e;
    e.name = name;
    e.f    = f;
    e.v    = v;
    e.due  = cyc;
    sb.push_back(e);
  endtask

  task automatic run(input int n, input logic ic);
    for (int i = 0; i < n; i++) begin
      inst_ce = ic;
      data_ce = 1'b0;
      data_we = 1'b0;
      step();
    end
  endtask

  task automatic bus(input logic [31:0] addr, input logic [31:0] data,
                     input logic ce, input logic we, input logic ic);
    inst_ce    = ic;
    data_ce    = ce;
    data_we    = we;
    data_addr  = addr;
    data_wdata = data;
    step();
    data_ce = 1'b0;
    data_we = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    rst     = 1'b0;
    inst_ce = 1'b0;
    data_ce = 1'b0;
    data_we = 1'b0;
    step();
    rst = 1'b1;
    expect_f({tag, "_rst_done"}, F_DONE, 0);
    expect_f({tag, "_rst_pass"}, F_PASS, 0);
    expect_f({tag, "_rst_cyc"},  F_CYC,  0);
    expect_f({tag, "_rst_sig0"}, F_SIG0, 0);
  endtask

  // ---------------------------------------------------------------------------
  // Directed scenarios
  // ---------------------------------------------------------------------------
  initial begin : stim
    exp_t e;

    // Reset state, both instances.
    rst = 1'b0;
    step();
    rst = 1'b1;
    expect_f("rst_done",  F_DONE, 0);
    expect_f("rst_pass",  F_PASS, 0);
    expect_f("rst_fail",  F_FAIL, 0);
    expect_f("rst_tmo",   F_TMO,  0);
    expect_f("rst_exit",  F_EXIT, 0);
    expect_f("rst_cyc",   F_CYC,  0);
    expect_f("rst_inst",  F_INST, 0);
    expect_f("rst_sig0",  F_SIG0, 0);
    expect_f("rst_sig3",  F_SIG3, 0);
    expect_f("rst_wdone", W_DONE, 0);
    expect_f("rst_wcyc",  W_CYC,  0);

    // Pass at RUN cycle 50, with ten fetch-idle cycles in the middle.
    run(1, 1'b1);                 // cycle 0
    run(9, 1'b1);                 // cycles 1..9
    run(10, 1'b0);                // cycles 10..19, no fetch
    run(30, 1'b1);                // cycles 20..49
    expect_f("p_pre_cyc",  F_CYC,  50);
    expect_f("p_pre_inst", F_INST, 40);
    expect_f("p_pre_done", F_DONE, 0);
    bus(TOHOST, 32'd1, 1'b1, 1'b1, 1'b1);  // cycle 50
    expect_f("p_pass", F_PASS, 1);
    expect_f("p_done", F_DONE, 1);
    expect_f("p_fail", F_FAIL, 0);
    expect_f("p_tmo",  F_TMO,  0);
    expect_f("p_cyc",  F_CYC,  51);
    expect_f("p_inst", F_INST, 41);
    run(100, 1'b1);
    expect_f("p_hold_pass", F_PASS, 1);
    expect_f("p_hold_done", F_DONE, 1);
    expect_f("p_hold_fail", F_FAIL, 0);
    expect_f("p_hold_tmo",  F_TMO,  0);
    expect_f("p_hold_cyc",  F_CYC,  51);
    expect_f("p_hold_inst", F_INST, 41);

    // Fail path, plus ignored even / non-strobed completion writes.
    do_reset("f");
    run(1, 1'b1);
    run(5, 1'b1);                                // cyc 6
    bus(TOHOST, 32'd2, 1'b1, 1'b1, 1'b1);        // even: ignored, cyc 7
    expect_f("f_even_done", F_DONE, 0);
    expect_f("f_even_fail", F_FAIL, 0);
    expect_f("f_even_pass", F_PASS, 0);
    run(2, 1'b1);                                // cyc 9
    bus(TOHOST, 32'd1, 1'b0, 1'b1, 1'b1);        // data_ce=0, cyc 10
    expect_f("f_noce_pass", F_PASS, 0);
    bus(TOHOST, 32'd1, 1'b1, 1'b0, 1'b1);        // data_we=0, cyc 11
    expect_f("f_nowe_pass", F_PASS, 0);
    bus(TOHOST, 32'h0000_0007, 1'b1, 1'b1, 1'b1);  // cyc 12
    expect_f("f_fail", F_FAIL, 1);
    expect_f("f_done", F_DONE, 1);
    expect_f("f_pass", F_PASS, 0);
    expect_f("f_exit", F_EXIT, 3);
    expect_f("f_cyc",  F_CYC,  12);
    bus(TOHOST, 32'd1, 1'b1, 1'b1, 1'b1);
    bus(TOHOST, 32'd9, 1'b1, 1'b1, 1'b1);
    expect_f("f_late_fail", F_FAIL, 1);
    expect_f("f_late_pass", F_PASS, 0);
    expect_f("f_late_exit", F_EXIT, 3);
    expect_f("f_late_cyc",  F_CYC,  12);

    // Watchdog expiry on the 20-cycle instance.
    do_reset("w");
    run(1, 1'b1);
    run(18, 1'b1);                               // wd cyc 19
    expect_f("w_pre_tmo",  W_TMO,  0);
    expect_f("w_pre_cyc",  W_CYC,  19);
    expect_f("w_pre_done", W_DONE, 0);
    run(1, 1'b1);                                // 20th RUN cycle
    expect_f("w_tmo",  W_TMO,  1);
    expect_f("w_done", W_DONE, 1);
    expect_f("w_pass", W_PASS, 0);
    expect_f("w_fail", W_FAIL, 0);
    expect_f("w_cyc",  W_CYC,  20);
    run(3, 1'b1);
    expect_f("w_hold_cyc", W_CYC, 20);
    expect_f("w_hold_tmo", W_TMO, 1);
    expect_f("w_dflt_tmo", F_TMO, 0);
    expect_f("w_dflt_cyc", F_CYC, 23);

    // Completion on the watchdog's final cycle wins.
    do_reset("wp");
    run(1, 1'b1);
    run(18, 1'b1);
    bus(TOHOST, 32'd1, 1'b1, 1'b1, 1'b1);        // 20th RUN cycle
    expect_f("wp_pass", W_PASS, 1);
    expect_f("wp_tmo",  W_TMO,  0);
    expect_f("wp_done", W_DONE, 1);
    expect_f("wp_cyc",  W_CYC,  20);
    run(5, 1'b1);
    expect_f("wp_hold_tmo",  W_TMO,  0);
    expect_f("wp_hold_pass", W_PASS, 1);

    // Signature capture.
    do_reset("s");
    bus(SIGB, 32'h99, 1'b1, 1'b1, 1'b0);         // IDLE: ignored, stays IDLE
    expect_f("s_idle_cyc",  F_CYC,  0);
    expect_f("s_idle_sig0", F_SIG0, 0);
    run(1, 1'b1);
    run(2, 1'b1);
    bus(SIGB + 32'd8,  32'hA5, 1'b1, 1'b1, 1'b1);
    bus(SIGB + 32'd2,  32'h11, 1'b1, 1'b1, 1'b1);  // misaligned
    bus(SIGB + 32'd16, 32'h22, 1'b1, 1'b1, 1'b1);  // past window
    bus(SIGB - 32'd4,  32'h66, 1'b1, 1'b1, 1'b1);  // below window
    bus(SIGB + 32'd4,  32'h33, 1'b0, 1'b1, 1'b1);  // data_ce=0
    bus(SIGB + 32'd4,  32'h44, 1'b1, 1'b0, 1'b1);  // data_we=0
    expect_f("s_sig0", F_SIG0, 0);
    expect_f("s_sig1", F_SIG1, 0);
    expect_f("s_sig2", F_SIG2, 32'hA5);
    expect_f("s_sig3", F_SIG3, 0);
    bus(SIGB + 32'd12, 32'h5A, 1'b1, 1'b1, 1'b1);
    expect_f("s_sig3_wr", F_SIG3, 32'h5A);
    bus(TOHOST, 32'd1, 1'b1, 1'b1, 1'b1);
    bus(SIGB, 32'h77, 1'b1, 1'b1, 1'b1);         // terminal: ignored
    expect_f("s_term_sig0", F_SIG0, 0);
    expect_f("s_term_pass", F_PASS, 1);

    // Reset in the middle of a run.
    do_reset("r");
    run(1, 1'b1);
    bus(SIGB, 32'hFF, 1'b1, 1'b1, 1'b1);         // cyc 2
    run(28, 1'b1);                               // cyc 30
    expect_f("r_pre_cyc",  F_CYC,  30);
    expect_f("r_pre_sig0", F_SIG0, 32'hFF);
    rst     = 1'b0;
    inst_ce = 1'b1;
    step();
    rst = 1'b1;
    expect_f("r_cyc",  F_CYC,  0);
    expect_f("r_inst", F_INST, 0);
    expect_f("r_sig0", F_SIG0, 0);
    expect_f("r_done", F_DONE, 0);
    run(3, 1'b0);
    expect_f("r_idle_cyc", F_CYC, 0);
    run(1, 1'b1);
    expect_f("r_resume_cyc",  F_CYC,  1);
    expect_f("r_resume_inst", F_INST, 1);
    run(2, 1'b0);
    expect_f("r_run_cyc",  F_CYC,  3);
    expect_f("r_run_inst", F_INST, 1);

    // Let the monitor drain, then account for anything left uncompared.
    run(2, 1'b0);
    @(negedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      n_tests++;
      n_fail++;
      $display("FAIL %s: never compared, expected 0x%0h", e.name, e.v);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : guard
    #1_000_000;
    $display("FAIL tb_time_limit: run did not finish, %0d tests run", n_tests);
    $fatal(1, "time limit");
  end

endmodule
